// File: rtl/any1_pkg.sv
// Shared ANY-1 pipeline types: execute result record, reorder entry and decode allocation payload.
package any1_pkg;

  localparam int unsigned AWID        = 32;
  localparam int unsigned RID_BITS    = 6;
  localparam int unsigned ROB_ENTRIES = 32;
  localparam int unsigned ROB_RIDW    = $clog2(ROB_ENTRIES);

  typedef struct packed {
    logic [RID_BITS-1:0] rid;
    logic [3:0]          Stream;
    logic                Stream_inc;
    logic [63:0]         ir;
    logic [AWID-1:0]     ia;
    logic                rfwr;
    logic [7:0]          Rt;
    logic [63:0]         res;
  } sExecuteOut;

  typedef struct packed {
    logic            v;
    logic            cmt;
    logic [AWID-1:0] ip;
    logic [63:0]     ir;
    logic [AWID-1:0] ia;
    logic            rfwr;
    logic [7:0]      Rt;
    logic [3:0]      Stream;
    logic            Stream_inc;
    logic [63:0]     res;
    logic [15:0]     cause;
  } sReorderEntry;

  typedef struct packed {
    logic [AWID-1:0] ip;
    logic [63:0]     ir;
    logic            rfwr;
    logic [7:0]      Rt;
  } sRobAlloc;

endpackage

// File: rtl/any1_rob_ptr.sv
// Circular buffer pointer: IDXW index bits plus a wrap bit, cleared by reset or flush.
module any1_rob_ptr #(
  parameter int unsigned IDXW = 5
) (
  input  logic          rst_i,
  input  logic          clk_i,
  input  logic          flush_i,
  input  logic          inc_i,
  output logic [IDXW:0] ptr_o
);

  localparam int unsigned PW = IDXW + 1;

  logic [IDXW:0] ptr_q, ptr_d;

  // Plain binary increment: the index wraps at 2**IDXW and carries into the wrap bit.
  always_comb begin
    ptr_d = ptr_q;
    if (flush_i)
      ptr_d = '0;
    else if (inc_i)
      ptr_d = ptr_q + PW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/any1_reorder_buffer.sv
// In-order reorder buffer: decode allocates by tail, execute completes by rid, commit retires from head.
module any1_reorder_buffer
  import any1_pkg::*;
#(
  parameter int unsigned ENTRIES = ROB_ENTRIES,
  parameter int unsigned RIDW    = RID_BITS,
  parameter int unsigned CNTW    = $clog2(ENTRIES + 1)
) (
  input  logic            rst_i,
  input  logic            clk_i,
  input  logic            flush_i,
  input  logic            alloc_req_i,
  input  logic [AWID-1:0] alloc_ip_i,
  input  logic [63:0]     alloc_ir_i,
  input  logic            alloc_rfwr_i,
  input  logic [7:0]      alloc_Rt_i,
  output logic            alloc_rdy_o,
  output logic [RIDW-1:0] alloc_rid_o,
  input  logic            done_v_i,
  input  sExecuteOut      done_i,
  input  logic [15:0]     done_cause_i,
  output logic            cmt_v_o,
  input  logic            cmt_rdy_i,
  output sReorderEntry    cmt_o,
  output logic [CNTW-1:0] count_o,
  output logic            empty_o
);

  localparam int unsigned IDXW = $clog2(ENTRIES);

  logic [IDXW:0]      head_ptr, tail_ptr;
  logic [IDXW-1:0]    head_idx, tail_idx, done_idx;
  logic               full, alloc_fire, done_fire, cmt_fire;
  logic [ENTRIES-1:0] v_q, v_d, cmt_q, cmt_d;
  sReorderEntry       rob_q [ENTRIES];
  sRobAlloc           alloc_pl;
  sReorderEntry       alloc_entry;
  logic               unused_done;

  assign head_idx = head_ptr[IDXW-1:0];
  assign tail_idx = tail_ptr[IDXW-1:0];
  assign done_idx = done_i.rid[IDXW-1:0];

  // The instruction word of a completion is already held from allocation.
  assign unused_done = ^{done_i.ir, done_i.rid};

  assign full = (head_idx == tail_idx) && (head_ptr[IDXW] != tail_ptr[IDXW]);

  assign alloc_fire = alloc_req_i & ~full & ~flush_i;
  assign done_fire  = done_v_i & ~flush_i & v_q[done_idx];
  assign cmt_v_o    = v_q[head_idx] & cmt_q[head_idx] & ~flush_i;
  assign cmt_fire   = cmt_v_o & cmt_rdy_i;

  assign alloc_rdy_o = ~full;
  assign alloc_rid_o = RIDW'(tail_idx);
  assign count_o     = CNTW'(tail_ptr - head_ptr);
  assign empty_o     = (tail_ptr == head_ptr);

  any1_rob_ptr #(.IDXW(IDXW)) u_head (
    .rst_i   (rst_i),
    .clk_i   (clk_i),
    .flush_i (flush_i),
    .inc_i   (cmt_fire),
    .ptr_o   (head_ptr)
  );

  any1_rob_ptr #(.IDXW(IDXW)) u_tail (
    .rst_i   (rst_i),
    .clk_i   (clk_i),
    .flush_i (flush_i),
    .inc_i   (alloc_fire),
    .ptr_o   (tail_ptr)
  );

  always_comb begin
    alloc_pl = '{ip: alloc_ip_i, ir: alloc_ir_i, rfwr: alloc_rfwr_i, Rt: alloc_Rt_i};
    alloc_entry      = '0;
    alloc_entry.ip   = alloc_pl.ip;
    alloc_entry.ir   = alloc_pl.ir;
    alloc_entry.rfwr = alloc_pl.rfwr;
    alloc_entry.Rt   = alloc_pl.Rt;
  end

  // Head entry with live status bits overlaid on the stored payload.
  always_comb begin
    cmt_o     = rob_q[head_idx];
    cmt_o.v   = v_q[head_idx];
    cmt_o.cmt = cmt_q[head_idx];
  end

  always_comb begin
    v_d   = v_q;
    cmt_d = cmt_q;
    if (flush_i) begin
      v_d   = '0;
      cmt_d = '0;
    end else begin
      if (done_fire)
        cmt_d[done_idx] = 1'b1;
      if (alloc_fire) begin
        v_d[tail_idx]   = 1'b1;
        cmt_d[tail_idx] = 1'b0;
      end
      if (cmt_fire) begin
        v_d[head_idx]   = 1'b0;
        cmt_d[head_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q   <= '0;
      cmt_q <= '0;
    end else begin
      v_q   <= v_d;
      cmt_q <= cmt_d;
    end
  end

  // Payload needs no reset: it is only observed through the valid bits.
  always_ff @(posedge clk_i) begin
    if (alloc_fire)
      rob_q[tail_idx] <= alloc_entry;
    if (done_fire) begin
      rob_q[done_idx].res        <= done_i.res;
      rob_q[done_idx].ia         <= done_i.ia;
      rob_q[done_idx].rfwr       <= done_i.rfwr;
      rob_q[done_idx].Rt         <= done_i.Rt;
      rob_q[done_idx].Stream     <= done_i.Stream;
      rob_q[done_idx].Stream_inc <= done_i.Stream_inc;
      rob_q[done_idx].cause      <= done_cause_i;
    end
  end

endmodule
